// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - encodings and helpers for the register-pair command sequencer
package regfile_seq_pkg;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'd0,
        CMD_RD_LO = 4'd1,
        CMD_RD_HI = 4'd2,
        CMD_WR_LO = 4'd3,
        CMD_WR_HI = 4'd4,
        CMD_INC1  = 4'd5,
        CMD_INC2  = 4'd6,
        CMD_DEC1  = 4'd7,
        CMD_DEC2  = 4'd8,
        CMD_ADDR  = 4'd9
    } cmd_e;

    typedef enum logic [2:0] {
        PAIR_BC = 3'd0,
        PAIR_DE = 3'd1,
        PAIR_HL = 3'd2,
        PAIR_WZ = 3'd3,
        PAIR_PC = 3'd4,
        PAIR_SP = 3'd5
    } pair_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LATCH = 3'd2,
        ST_CALC  = 3'd3,
        ST_RSTB  = 3'd4,
        ST_WSTB  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    localparam logic [3:0] CMD_LAST  = 4'd9;
    localparam logic [2:0] PAIR_LAST = 3'd5;

    // Registered control bundle driven towards the register file and control unit
    typedef struct packed {
        logic rreg_rd;
        logic lreg_rd;
        logic rreg_wr;
        logic lreg_wr;
        logic dreg_rd;
        logic dreg_wr;
        logic dreg_inc;
        logic dreg_dec;
        logic dreg_cnt;
        logic dreg_cnt2;
        logic ack;
        logic err;
        logic busy;
    } strobe_t;

    // Select order is {sp, pc, wz, hl, de, bc}; an out-of-range pair selects nothing
    function automatic logic [5:0] pair_onehot(input pair_e p);
        logic [5:0] oh;
        oh = 6'b000000;
        case (p)
            PAIR_BC: oh = 6'b000001;
            PAIR_DE: oh = 6'b000010;
            PAIR_HL: oh = 6'b000100;
            PAIR_WZ: oh = 6'b001000;
            PAIR_PC: oh = 6'b010000;
            PAIR_SP: oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - expands register-pair transfer commands into select/strobe sequences
module regfile_seq
    import regfile_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] cmd,
    input  logic [2:0] sel,
    output logic       ack,
    output logic       err,
    output logic       busy,
    output logic       bc_rw,
    output logic       de_rw,
    output logic       hl_rw,
    output logic       wz_rw,
    output logic       pc_rw,
    output logic       sp_rw,
    output logic       rreg_rd,
    output logic       lreg_rd,
    output logic       rreg_wr,
    output logic       lreg_wr,
    output logic       dreg_rd,
    output logic       dreg_wr,
    output logic       dreg_inc,
    output logic       dreg_dec,
    output logic       dreg_cnt,
    output logic       dreg_cnt2,
    input  logic       carry_in,
    output logic       carry
);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    pair_e       sel_q, sel_d;
    logic        bad_q, bad_d;
    logic [5:0]  pair_q, pair_d;
    strobe_t     stb_q, stb_d;
    logic        carry_q, carry_d;

    logic illegal;
    logic active;
    logic is_inc;
    logic is_dec;
    logic incdec;

    // Next-state sequencing and capture of the accepted command
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        sel_d   = sel_q;
        bad_d   = bad_q;
        illegal = (cmd == 4'd0) || (cmd > CMD_LAST) || (sel > PAIR_LAST);
        is_inc  = (cmd_q == CMD_INC1) || (cmd_q == CMD_INC2);
        is_dec  = (cmd_q == CMD_DEC1) || (cmd_q == CMD_DEC2);
        incdec  = is_inc || is_dec;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cmd_d   = cmd_e'(cmd);
                    sel_d   = pair_e'(sel);
                    bad_d   = illegal;
                    state_d = illegal ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                case (cmd_q)
                    CMD_RD_LO, CMD_RD_HI: state_d = ST_RSTB;
                    CMD_WR_LO, CMD_WR_HI: state_d = ST_WSTB;
                    default:              state_d = ST_LATCH;
                endcase
            end
            ST_LATCH: state_d = incdec ? ST_CALC : ST_HOLD;
            ST_CALC:  state_d = ST_WSTB;
            ST_RSTB:  state_d = ST_HOLD;
            ST_WSTB:  state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode of the current state; registered so every line lags the state by one cycle
    always_comb begin
        stb_d   = '0;
        active  = (state_q != ST_IDLE) && (state_q != ST_DONE);
        pair_d  = active ? pair_onehot(sel_q) : 6'b000000;
        carry_d = stb_q.dreg_wr ? carry_in : carry_q;

        stb_d.rreg_rd   = (cmd_q == CMD_RD_LO) && ((state_q == ST_RSTB) || (state_q == ST_HOLD));
        stb_d.lreg_rd   = (cmd_q == CMD_RD_HI) && ((state_q == ST_RSTB) || (state_q == ST_HOLD));
        stb_d.rreg_wr   = (cmd_q == CMD_WR_LO) && (state_q == ST_WSTB);
        stb_d.lreg_wr   = (cmd_q == CMD_WR_HI) && (state_q == ST_WSTB);
        stb_d.dreg_rd   = (state_q == ST_LATCH);
        stb_d.dreg_wr   = incdec && (state_q == ST_WSTB);
        stb_d.dreg_inc  = active && is_inc;
        stb_d.dreg_dec  = active && is_dec;
        stb_d.dreg_cnt  = active && ((cmd_q == CMD_INC1) || (cmd_q == CMD_DEC1));
        stb_d.dreg_cnt2 = active && ((cmd_q == CMD_INC2) || (cmd_q == CMD_DEC2));
        stb_d.ack       = (state_q == ST_DONE);
        stb_d.err       = (state_q == ST_DONE) && bad_q;
        stb_d.busy      = (state_q != ST_IDLE) || req;
    end

    // State, captured command and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            sel_q   <= PAIR_BC;
            bad_q   <= 1'b0;
            pair_q  <= 6'b000000;
            stb_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            bad_q   <= bad_d;
            pair_q  <= pair_d;
            stb_q   <= stb_d;
            carry_q <= carry_d;
        end
    end

    assign {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} = pair_q;
    assign rreg_rd   = stb_q.rreg_rd;
    assign lreg_rd   = stb_q.lreg_rd;
    assign rreg_wr   = stb_q.rreg_wr;
    assign lreg_wr   = stb_q.lreg_wr;
    assign dreg_rd   = stb_q.dreg_rd;
    assign dreg_wr   = stb_q.dreg_wr;
    assign dreg_inc  = stb_q.dreg_inc;
    assign dreg_dec  = stb_q.dreg_dec;
    assign dreg_cnt  = stb_q.dreg_cnt;
    assign dreg_cnt2 = stb_q.dreg_cnt2;
    assign ack       = stb_q.ack;
    assign err       = stb_q.err;
    assign busy      = stb_q.busy;
    assign carry     = carry_q;

endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - directed vector bench for the register-pair command sequencer
module tb_regfile_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [3:0] cmd;
    logic [2:0] sel;
    logic       ack, err, busy;
    logic       bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
    logic       rreg_rd, lreg_rd, rreg_wr, lreg_wr;
    logic       dreg_rd, dreg_wr, dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2;
    logic       carry_in;
    logic       carry;

    int checks = 0;
    int errors = 0;

    regfile_seq dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .sel(sel),
        .ack(ack), .err(err), .busy(busy),
        .bc_rw(bc_rw), .de_rw(de_rw), .hl_rw(hl_rw), .wz_rw(wz_rw), .pc_rw(pc_rw), .sp_rw(sp_rw),
        .rreg_rd(rreg_rd), .lreg_rd(lreg_rd), .rreg_wr(rreg_wr), .lreg_wr(lreg_wr),
        .dreg_rd(dreg_rd), .dreg_wr(dreg_wr), .dreg_inc(dreg_inc), .dreg_dec(dreg_dec),
        .dreg_cnt(dreg_cnt), .dreg_cnt2(dreg_cnt2),
        .carry_in(carry_in), .carry(carry)
    );

    always #5 clk = ~clk;

    // Masks: bit c is the expected level in cycle c, cycle 0 being the one after the accepting edge
    typedef struct {
        string      name;
        logic [3:0] cmd;
        logic [2:0] sel;
        logic       cin;
        logic [5:0] onehot;
        logic [7:0] m_sel, m_rrd, m_lrd, m_rwr, m_lwr, m_drd, m_dwr;
        logic [7:0] m_inc, m_dec, m_cnt, m_cnt2, m_ack, m_err, m_busy;
        logic       carry;
    } vec_t;

    vec_t vecs[14];
    vec_t rd_after_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] sels();
        return {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw};
    endfunction

    function automatic logic [21:0] all_outs();
        return {ack, err, busy, sels(), rreg_rd, lreg_rd, rreg_wr, lreg_wr,
                dreg_rd, dreg_wr, dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2, carry};
    endfunction

    task automatic run_vec(input vec_t v);
        logic [7:0] a_sel, a_rrd, a_lrd, a_rwr, a_lwr, a_drd, a_dwr;
        logic [7:0] a_inc, a_dec, a_cnt, a_cnt2, a_ack, a_err, a_busy;
        logic       oh_bad, inv_bad;
        a_sel = '0; a_rrd = '0; a_lrd = '0; a_rwr = '0; a_lwr = '0; a_drd = '0; a_dwr = '0;
        a_inc = '0; a_dec = '0; a_cnt = '0; a_cnt2 = '0; a_ack = '0; a_err = '0; a_busy = '0;
        oh_bad = 1'b0;
        inv_bad = 1'b0;
        @(negedge clk);
        req = 1'b1;
        cmd = v.cmd;
        sel = v.sel;
        carry_in = v.cin;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_sel[c]  = |sels();
            a_rrd[c]  = rreg_rd;
            a_lrd[c]  = lreg_rd;
            a_rwr[c]  = rreg_wr;
            a_lwr[c]  = lreg_wr;
            a_drd[c]  = dreg_rd;
            a_dwr[c]  = dreg_wr;
            a_inc[c]  = dreg_inc;
            a_dec[c]  = dreg_dec;
            a_cnt[c]  = dreg_cnt;
            a_cnt2[c] = dreg_cnt2;
            a_ack[c]  = ack;
            a_err[c]  = err;
            a_busy[c] = busy;
            if ((|sels()) && (sels() !== v.onehot)) oh_bad = 1'b1;
            if ((rreg_rd | lreg_rd | dreg_rd) && (rreg_wr | lreg_wr | dreg_wr)) inv_bad = 1'b1;
            if (c == 0) begin
                cmd = v.cmd ^ 4'hA;
                sel = ~v.sel;
            end
            if (ack) req = 1'b0;
        end
        req = 1'b0;
        chk({v.name, " sel"},  a_sel,  v.m_sel);
        chk({v.name, " rrd"},  a_rrd,  v.m_rrd);
        chk({v.name, " lrd"},  a_lrd,  v.m_lrd);
        chk({v.name, " rwr"},  a_rwr,  v.m_rwr);
        chk({v.name, " lwr"},  a_lwr,  v.m_lwr);
        chk({v.name, " drd"},  a_drd,  v.m_drd);
        chk({v.name, " dwr"},  a_dwr,  v.m_dwr);
        chk({v.name, " inc"},  a_inc,  v.m_inc);
        chk({v.name, " dec"},  a_dec,  v.m_dec);
        chk({v.name, " cnt"},  a_cnt,  v.m_cnt);
        chk({v.name, " cnt2"}, a_cnt2, v.m_cnt2);
        chk({v.name, " ack"},  a_ack,  v.m_ack);
        chk({v.name, " err"},  a_err,  v.m_err);
        chk({v.name, " busy"}, a_busy, v.m_busy);
        chk({v.name, " onehot"}, oh_bad, 1'b0);
        chk({v.name, " rw_excl"}, inv_bad, 1'b0);
        chk({v.name, " carry"}, carry, v.carry);
    endtask

    initial begin
        int ack1, ack2, nacks, first;
        logic busy_gap;

        //          name        cmd   sel   cin onehot   sel    rrd    lrd    rwr    lwr    drd    dwr    inc    dec    cnt    cnt2   ack    err    busy   carry
        vecs[0]  = '{"rd_lo_hl", 4'd1, 3'd2, 1'b0, 6'h04, 8'h0E, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b0};
        vecs[1]  = '{"rd_hi_bc", 4'd2, 3'd0, 1'b1, 6'h01, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b0};
        vecs[2]  = '{"wr_hi_sp", 4'd4, 3'd5, 1'b1, 6'h20, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b0};
        vecs[3]  = '{"inc2_pc",  4'd6, 3'd4, 1'b1, 6'h10, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h3E, 8'h00, 8'h00, 8'h3E, 8'h40, 8'h00, 8'h7F, 1'b1};
        vecs[4]  = '{"wr_lo_de", 4'd3, 3'd1, 1'b0, 6'h02, 8'h0E, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b1};
        vecs[5]  = '{"dec1_bc",  4'd7, 3'd0, 1'b0, 6'h01, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 8'h3E, 8'h3E, 8'h00, 8'h40, 8'h00, 8'h7F, 1'b0};
        vecs[6]  = '{"addr_hl",  4'd9, 3'd2, 1'b1, 6'h04, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b0};
        vecs[7]  = '{"dec2_sp",  4'd8, 3'd5, 1'b1, 6'h20, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 8'h3E, 8'h00, 8'h3E, 8'h40, 8'h00, 8'h7F, 1'b1};
        vecs[8]  = '{"inc1_wz",  4'd5, 3'd3, 1'b0, 6'h08, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h3E, 8'h00, 8'h3E, 8'h00, 8'h40, 8'h00, 8'h7F, 1'b0};
        vecs[9]  = '{"inc1_de",  4'd5, 3'd1, 1'b1, 6'h02, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h3E, 8'h00, 8'h3E, 8'h00, 8'h40, 8'h00, 8'h7F, 1'b1};
        vecs[10] = '{"nop",      4'd0, 3'd0, 1'b0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03, 1'b1};
        vecs[11] = '{"sel6",     4'd1, 3'd6, 1'b0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03, 1'b1};
        vecs[12] = '{"cmd12",    4'd12, 3'd1, 1'b0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03, 1'b1};
        vecs[13] = '{"sel7_inc", 4'd6, 3'd7, 1'b0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03, 1'b1};
        rd_after_rst = '{"rd_after_rst", 4'd1, 3'd2, 1'b1, 6'h04, 8'h0E, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h1F, 1'b0};

        rst = 1'b1;
        req = 1'b0;
        cmd = 4'd0;
        sel = 3'd0;
        carry_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 22'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", all_outs(), 22'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset in the middle of a DEC1 clears everything asynchronously and no ack follows
        @(negedge clk);
        req = 1'b1; cmd = 4'd7; sel = 3'd0; carry_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", all_outs(), 22'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nacks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack) nacks++;
        end
        chk("rst_mid_noack", nacks, 0);
        run_vec(rd_after_rst);

        // Back-to-back with req held: second command accepted the cycle after the first ack
        @(negedge clk);
        req = 1'b1; cmd = 4'd1; sel = 3'd2;
        ack1 = -1; ack2 = -1; busy_gap = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ack1 >= 0 && c == ack1 + 1) busy_gap = busy;
            if (ack) begin
                if (ack1 < 0) begin
                    ack1 = c; cmd = 4'd3; sel = 3'd1;
                end else if (ack2 < 0) begin
                    ack2 = c; req = 1'b0;
                end
            end
        end
        req = 1'b0;
        chk("b2b_ack1", ack1, 4);
        chk("b2b_ack2", ack2, 9);
        chk("b2b_busy_after_ack", busy_gap, 1'b1);

        // A req pulse raised while busy is dropped, not queued
        @(negedge clk);
        req = 1'b1; cmd = 4'd5; sel = 3'd0; carry_in = 1'b0;
        nacks = 0; first = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            if (c == 2) begin req = 1'b1; cmd = 4'd1; end
            if (c == 3) req = 1'b0;
            if (ack) begin nacks++; first = c; end
        end
        chk("busy_req_nacks", nacks, 1);
        chk("busy_req_ack_at", first, 6);
        chk("busy_req_carry", carry, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
